// File: rtl/decoder_pkg.sv
// Shared definitions for the pipelined instruction decoder:
// opcode constants, the instruction-class enum and the decoded bundle layout.
package decoder_pkg;

  localparam int OPCODE_BITS = 6;

  localparam logic [OPCODE_BITS-1:0] OP_R    = 6'b000000;
  localparam logic [OPCODE_BITS-1:0] OP_ADDI = 6'b000001;
  localparam logic [OPCODE_BITS-1:0] OP_SUBI = 6'b000010;
  localparam logic [OPCODE_BITS-1:0] OP_LW   = 6'b001000;
  localparam logic [OPCODE_BITS-1:0] OP_SW   = 6'b001001;
  localparam logic [OPCODE_BITS-1:0] OP_BEQ  = 6'b010010;
  localparam logic [OPCODE_BITS-1:0] OP_BNE  = 6'b010011;
  localparam logic [OPCODE_BITS-1:0] OP_LI   = 6'b011000;
  localparam logic [OPCODE_BITS-1:0] OP_J    = 6'b010000;

  typedef enum logic [1:0] {
    TYPE_R   = 2'd0,
    TYPE_I   = 2'd1,
    TYPE_J   = 2'd2,
    TYPE_ILL = 2'd3
  } instr_type_e;

  // Decoded bundle for the default geometry (6/5/5/5/16, 32-bit XLEN and PC).
  // The decoder packs the same field order generically for other widths.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [10:0] funct;
    logic [31:0] imm;
    logic [25:0] jaddr;
    instr_type_e itype;
    logic [31:0] pc;
  } decoded_t;

endpackage

// File: rtl/decode_fifo.sv
// Two-entry in-order buffer with valid/ready on both sides.
// Acceptance depends only on the stored count, so a full buffer refuses a
// push even when the head is popped in the same cycle.
module decode_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_valid,
  output logic         push_ready,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic [1:0]   count_next;
  logic         do_push;
  logic         do_pop;

  assign push_ready = (count_reg < 2'd2);
  assign pop_valid  = (count_reg != 2'd0);
  assign pop_data   = mem_reg[rd_ptr_reg];
  assign do_push    = push_valid && push_ready;
  assign do_pop     = pop_valid && pop_ready;

  // Occupancy after this cycle's transfers (flush/reset handled in the register).
  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  // Pointers and count; flush empties the buffer and drops any same-cycle push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else if (flush) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
    end else if (!flush && do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/pipelined_decoder.sv
// Instruction decoder: fields are split and classified combinationally from
// the incoming word, then the decoded bundle plus PC is queued in a 2-entry
// buffer. Also counts accepted illegal instructions (saturating).
module pipelined_decoder
  import decoder_pkg::*;
#(
  parameter int INSTR_W  = 37,
  parameter int OPCODE_W = 6,
  parameter int REG_W    = 5,
  parameter int IMM_W    = 16,
  parameter int XLEN     = 32,
  parameter int PC_W     = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [INSTR_W-1:0]                in_instr,
  input  logic [PC_W-1:0]                   in_pc,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OPCODE_W-1:0]               out_opcode,
  output logic [REG_W-1:0]                  out_rs1,
  output logic [REG_W-1:0]                  out_rs2,
  output logic [REG_W-1:0]                  out_rd,
  output logic [REG_W-1:0]                  out_shamt,
  output logic [IMM_W-REG_W-1:0]            out_funct,
  output logic [XLEN-1:0]                   out_imm,
  output logic [INSTR_W-OPCODE_W-REG_W-1:0] out_jaddr,
  output logic [1:0]                        out_type,
  output logic [PC_W-1:0]                   out_pc,
  output logic [15:0]                       illegal_count
);

  localparam int FUNCT_W = IMM_W - REG_W;
  localparam int JADDR_W = INSTR_W - OPCODE_W - REG_W;
  localparam int PAY_W   = OPCODE_W + 4*REG_W + FUNCT_W + XLEN + JADDR_W + 2 + PC_W;

  // Geometry sanity checks at elaboration.
  if (INSTR_W != OPCODE_W + 3*REG_W + IMM_W) begin : g_bad_instr_w
    $error("INSTR_W must equal OPCODE_W + 3*REG_W + IMM_W");
  end
  if (XLEN < IMM_W) begin : g_bad_xlen
    $error("XLEN must be >= IMM_W");
  end
  if (IMM_W <= REG_W) begin : g_bad_imm_w
    $error("IMM_W must exceed REG_W so the funct field is non-empty");
  end

  logic [OPCODE_W-1:0] dec_opcode;
  logic [REG_W-1:0]    dec_rs1;
  logic [REG_W-1:0]    dec_rs2;
  logic [REG_W-1:0]    dec_rd;
  logic [IMM_W-1:0]    dec_imm_raw;
  logic [REG_W-1:0]    dec_shamt;
  logic [FUNCT_W-1:0]  dec_funct;
  logic [JADDR_W-1:0]  dec_jaddr;
  logic [XLEN-1:0]     dec_imm;
  instr_type_e         dec_type;
  logic                dec_zero_ext;

  logic [PAY_W-1:0]    push_payload;
  logic [PAY_W-1:0]    head_payload;
  logic                push_fire;
  logic [1:0]          head_type;

  logic [15:0]         illegal_count_reg;

  // Fixed field positions, opcode at the top of the word.
  assign dec_opcode  = in_instr[INSTR_W-1 -: OPCODE_W];
  assign dec_rs1     = in_instr[INSTR_W-OPCODE_W-1 -: REG_W];
  assign dec_rs2     = in_instr[INSTR_W-OPCODE_W-REG_W-1 -: REG_W];
  assign dec_rd      = in_instr[INSTR_W-OPCODE_W-2*REG_W-1 -: REG_W];
  assign dec_imm_raw = in_instr[IMM_W-1:0];
  assign dec_shamt   = dec_imm_raw[IMM_W-1 -: REG_W];
  assign dec_funct   = dec_imm_raw[FUNCT_W-1:0];
  assign dec_jaddr   = in_instr[JADDR_W-1:0];

  // Classify the opcode; only LI takes a zero-extended immediate.
  always_comb begin
    dec_type     = TYPE_ILL;
    dec_zero_ext = 1'b0;
    case (dec_opcode)
      OPCODE_W'(OP_R):    dec_type = TYPE_R;
      OPCODE_W'(OP_ADDI): dec_type = TYPE_I;
      OPCODE_W'(OP_SUBI): dec_type = TYPE_I;
      OPCODE_W'(OP_LW):   dec_type = TYPE_I;
      OPCODE_W'(OP_SW):   dec_type = TYPE_I;
      OPCODE_W'(OP_BEQ):  dec_type = TYPE_I;
      OPCODE_W'(OP_BNE):  dec_type = TYPE_I;
      OPCODE_W'(OP_LI): begin
        dec_type     = TYPE_I;
        dec_zero_ext = 1'b1;
      end
      OPCODE_W'(OP_J):    dec_type = TYPE_J;
      default:            dec_type = TYPE_ILL;
    endcase
  end

  assign dec_imm = dec_zero_ext ? XLEN'(dec_imm_raw) : XLEN'($signed(dec_imm_raw));

  assign push_payload = {dec_opcode, dec_rs1, dec_rs2, dec_rd, dec_shamt, dec_funct,
                         dec_imm, dec_jaddr, dec_type, in_pc};

  decode_fifo #(
    .W (PAY_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (push_payload),
    .pop_valid  (out_valid),
    .pop_ready  (out_ready),
    .pop_data   (head_payload)
  );

  assign {out_opcode, out_rs1, out_rs2, out_rd, out_shamt, out_funct,
          out_imm, out_jaddr, head_type, out_pc} = head_payload;
  assign out_type = head_type;

  assign push_fire = in_valid && in_ready;

  // Saturating count of accepted illegal instructions; flush leaves it alone
  // but a push dropped by flush is not counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_count_reg <= 16'd0;
    end else if (push_fire && !flush && (dec_type == TYPE_ILL) &&
                 (illegal_count_reg != 16'hFFFF)) begin
      illegal_count_reg <= illegal_count_reg + 16'd1;
    end
  end

  assign illegal_count = illegal_count_reg;

endmodule

// File: tb/tb_pipelined_decoder.sv
// Self-checking bench for pipelined_decoder: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_pipelined_decoder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [36:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [10:0] out_funct;
  logic [31:0] out_imm;
  logic [25:0] out_jaddr;
  logic [1:0]  out_type;
  logic [31:0] out_pc;
  logic [15:0] illegal_count;

  pipelined_decoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd        (out_rd),
    .out_shamt     (out_shamt),
    .out_funct     (out_funct),
    .out_imm       (out_imm),
    .out_jaddr     (out_jaddr),
    .out_type      (out_type),
    .out_pc        (out_pc),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint unsigned opcode, rs1, rs2, rd, shamt, funct, imm, jaddr, itype, pc;
  } exp_t;

  exp_t        q[$];
  int unsigned ill_model;
  bit          zero_fields;
  int          total;
  int          bad;

  task automatic chk(string tag, longint unsigned got, longint unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set table.
  function automatic exp_t ref_decode(longint unsigned ins, longint unsigned pc);
    exp_t e;
    e.opcode = (ins >> 31) & 64'h3F;
    e.rs1    = (ins >> 26) & 64'h1F;
    e.rs2    = (ins >> 21) & 64'h1F;
    e.rd     = (ins >> 16) & 64'h1F;
    e.shamt  = (ins >> 11) & 64'h1F;
    e.funct  = ins & 64'h7FF;
    e.jaddr  = ins & 64'h3FF_FFFF;
    e.pc     = pc;
    case (e.opcode)
      0:                     e.itype = 0;
      1, 2, 8, 9, 18, 19, 24: e.itype = 1;
      16:                    e.itype = 2;
      default:               e.itype = 3;
    endcase
    if (e.opcode == 24) e.imm = ins & 64'hFFFF;
    else if ((ins & 64'h8000) != 0) e.imm = (ins & 64'hFFFF) + 64'hFFFF_0000;
    else e.imm = ins & 64'hFFFF;
    return e;
  endfunction

  task automatic check_outputs(string ctx);
    chk({ctx, ":out_valid"}, out_valid, (q.size() > 0) ? 1 : 0);
    chk({ctx, ":in_ready"}, in_ready, (q.size() < 2) ? 1 : 0);
    chk({ctx, ":illegal_count"}, illegal_count, ill_model);
    if (q.size() > 0) begin
      chk({ctx, ":opcode"}, out_opcode, q[0].opcode);
      chk({ctx, ":rs1"},    out_rs1,    q[0].rs1);
      chk({ctx, ":rs2"},    out_rs2,    q[0].rs2);
      chk({ctx, ":rd"},     out_rd,     q[0].rd);
      chk({ctx, ":shamt"},  out_shamt,  q[0].shamt);
      chk({ctx, ":funct"},  out_funct,  q[0].funct);
      chk({ctx, ":imm"},    out_imm,    q[0].imm);
      chk({ctx, ":jaddr"},  out_jaddr,  q[0].jaddr);
      chk({ctx, ":type"},   out_type,   q[0].itype);
      chk({ctx, ":pc"},     out_pc,     q[0].pc);
    end else if (zero_fields) begin
      chk({ctx, ":rst_opcode"}, out_opcode, 0);
      chk({ctx, ":rst_imm"},    out_imm,    0);
      chk({ctx, ":rst_jaddr"},  out_jaddr,  0);
      chk({ctx, ":rst_pc"},     out_pc,     0);
    end
  endtask

  // One clock: drive, advance the model at the edge, then compare.
  task automatic step(string ctx, bit rn, bit fl, bit iv, logic [36:0] ins,
                      logic [31:0] p, bit ordy);
    bit   push_ok;
    bit   pop_ok;
    exp_t e;
    rst_n     = rn;
    flush     = fl;
    in_valid  = iv;
    in_instr  = ins;
    in_pc     = p;
    out_ready = ordy;
    push_ok = iv && (q.size() < 2);
    pop_ok  = (q.size() > 0) && ordy;
    e = ref_decode(64'(ins), 64'(p));
    @(posedge clk);
    if (!rn) begin
      q.delete();
      ill_model   = 0;
      zero_fields = 1;
    end else if (fl) begin
      q.delete();
    end else begin
      if (pop_ok) void'(q.pop_front());
      if (push_ok) begin
        q.push_back(e);
        zero_fields = 0;
        if (e.itype == 3 && ill_model < 16'hFFFF) ill_model++;
      end
    end
    #1;
    check_outputs(ctx);
    $display("step %-10s rst_n=%0b flush=%0b in_v=%0b instr=%010h ordy=%0b -> out_v=%0b type=%0d imm=%08h ill=%0d",
             ctx, rn, fl, iv, ins, ordy, out_valid, out_type, out_imm, illegal_count);
  endtask

  function automatic logic [36:0] mk(logic [5:0] op, logic [15:0] imm);
    logic [36:0] r;
    r = {$urandom, $urandom};
    r[36:31] = op;
    r[15:0]  = imm;
    return r;
  endfunction

  logic [5:0] legal_ops [9];

  initial begin
    total = 0;
    bad = 0;
    ill_model = 0;
    zero_fields = 1;
    legal_ops = '{6'd0, 6'd1, 6'd2, 6'd8, 6'd9, 6'd18, 6'd19, 6'd24, 6'd16};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;

    // Reset
    step("reset", 0, 0, 0, '0, 0, 0);
    step("reset", 0, 0, 1, mk(6'd1, 16'h1234), 32'h44, 1);
    step("idle", 1, 0, 0, '0, 0, 1);

    // Single R-type, one-cycle latency, then empty
    step("add", 1, 0, 1, 37'h0, 32'h100, 1);
    step("add_next", 1, 0, 0, '0, 0, 1);

    // Immediate extension
    step("addi", 1, 0, 1, mk(6'd1, 16'hFFFF), 32'h104, 1);
    step("li", 1, 0, 1, mk(6'd24, 16'hFFFF), 32'h108, 1);
    step("li_out", 1, 0, 0, '0, 0, 1);

    // Backpressure: three pushes, third refused, ordered drain
    step("bp1", 1, 0, 1, mk(6'd2, 16'h0001), 32'h200, 0);
    step("bp2", 1, 0, 1, mk(6'd8, 16'h8000), 32'h204, 0);
    step("bp3", 1, 0, 1, mk(6'd16, 16'h0002), 32'h208, 0);
    step("bp_hold", 1, 0, 0, '0, 0, 0);
    step("drain1", 1, 0, 0, '0, 0, 1);
    step("drain2", 1, 0, 0, '0, 0, 1);

    // Flush with two buffered and a concurrent push
    step("fl_fill1", 1, 0, 1, mk(6'd9, 16'h0010), 32'h300, 0);
    step("fl_fill2", 1, 0, 1, mk(6'd18, 16'h0020), 32'h304, 0);
    step("flush", 1, 1, 1, mk(6'd19, 16'h0030), 32'h308, 1);
    step("post_fl", 1, 0, 0, '0, 0, 1);

    // Illegal counting, one push lost to flush
    step("ill1", 1, 0, 1, mk(6'h3F, 16'h0001), 32'h400, 1);
    step("ill2", 1, 1, 1, mk(6'h3F, 16'h0002), 32'h404, 1);
    step("ill3", 1, 0, 1, mk(6'h3F, 16'h0003), 32'h408, 1);
    step("ill_out", 1, 0, 0, '0, 0, 1);
    chk("ill_count_two", illegal_count, 2);

    // Saturation: preload the counter then push more illegals
    force dut.illegal_count_reg = 16'hFFFF;
    #1;
    release dut.illegal_count_reg;
    ill_model = 16'hFFFF;
    #1;
    chk("ill_preload", illegal_count, ill_model);
    step("sat1", 1, 0, 1, mk(6'h3F, 16'h0004), 32'h500, 1);
    step("sat2", 1, 0, 1, mk(6'h2A, 16'h0005), 32'h504, 1);
    step("sat_out", 1, 0, 0, '0, 0, 1);

    // Mid-stream reset with full buffer
    step("rs_fill1", 1, 0, 1, mk(6'h3E, 16'h0006), 32'h600, 0);
    step("rs_fill2", 1, 0, 1, mk(6'd1, 16'h0007), 32'h604, 0);
    step("mid_reset", 0, 1, 1, mk(6'h3F, 16'h0008), 32'h608, 1);
    step("after_rst", 1, 0, 0, '0, 0, 1);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [5:0]  op;
      logic [36:0] ins;
      bit rn, fl, iv, rd;
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 8)];
      ins = mk(op, 16'($urandom));
      rn = ($urandom_range(0, 99) != 0);
      fl = ($urandom_range(0, 19) == 0);
      iv = ($urandom_range(0, 9) < 7);
      rd = ($urandom_range(0, 9) < 6);
      step("rand", rn, fl, iv, ins, $urandom, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
